// File: rtl/stonyman_pkg.sv
// Shared definitions for the Stonyman sensor model: register map, ADC frame layout and FSM states.
// Also used by the imager and its bench.
package stonyman_pkg;

    localparam logic [2:0] REG_COLSEL = 3'd0;
    localparam logic [2:0] REG_ROWSEL = 3'd1;
    localparam logic [2:0] REG_VSW    = 3'd2;
    localparam logic [2:0] REG_HSW    = 3'd3;
    localparam logic [2:0] REG_VREF   = 3'd4;
    localparam logic [2:0] REG_CONFIG = 3'd5;
    localparam logic [2:0] REG_NBIAS  = 3'd6;
    localparam logic [2:0] REG_AOBIAS = 3'd7;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_LEAD_ZEROS = 3;
    localparam int unsigned ADC_DATA_BITS  = 8;
    localparam int unsigned ADC_TAIL_ZEROS = ADC_FRAME_BITS - ADC_LEAD_ZEROS - ADC_DATA_BITS;

    typedef enum logic [1:0] {
        AdcIdle,
        AdcShift,
        AdcDone
    } adc_state_e;

    function automatic logic [ADC_FRAME_BITS-1:0] adc_frame(input logic [ADC_DATA_BITS-1:0] pixel);
        return {{ADC_LEAD_ZEROS{1'b0}}, pixel, {ADC_TAIL_ZEROS{1'b0}}};
    endfunction

endpackage

// File: rtl/stonyman_if.sv
// Camera port between the imager (master) and the Stonyman sensor/ADC (slave).
interface stonyman_if;
    logic resp;
    logic incp;
    logic resv;
    logic incv;
    logic inphi;
    logic sclk;
    logic cs_n;
    logic sdata;

    modport master (
        output resp, incp, resv, incv, inphi, sclk, cs_n,
        input  sdata
    );

    modport slave (
        input  resp, incp, resv, incv, inphi, sclk, cs_n,
        output sdata
    );
endinterface

// File: rtl/stonyman_adc_shifter.sv
// Serial ADC emulation: snapshots a pixel on cs_n fall and shifts a 16-bit frame out MSB first,
// advancing one bit per detected sclk falling edge.
module stonyman_adc_shifter
    import stonyman_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sclk_i,
    input  logic                     cs_n_i,
    input  logic [ADC_DATA_BITS-1:0] pixel_i,
    output logic                     sdata_o,
    output logic [15:0]              conv_count_o,
    output logic                     abort_err_o
);

    adc_state_e                state_q, state_d;
    logic [ADC_FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]                fall_cnt_q, fall_cnt_d;
    logic                      sdata_q, sdata_d;
    logic [15:0]               count_q, count_d;
    logic                      abort_q, abort_d;
    logic                      sclk_prev_q, cs_n_prev_q;
    logic                      cs_fall, cs_rise, sclk_fall;
    logic [ADC_FRAME_BITS-1:0] frame;

    // sclk activity only matters while the chip is selected
    assign cs_fall   = cs_n_prev_q & ~cs_n_i;
    assign cs_rise   = ~cs_n_prev_q & cs_n_i;
    assign sclk_fall = sclk_prev_q & ~sclk_i & ~cs_n_i;
    assign frame     = adc_frame(pixel_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= AdcIdle;
            shift_q     <= '0;
            fall_cnt_q  <= '0;
            sdata_q     <= 1'b0;
            count_q     <= '0;
            abort_q     <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            fall_cnt_q  <= fall_cnt_d;
            sdata_q     <= sdata_d;
            count_q     <= count_d;
            abort_q     <= abort_d;
            sclk_prev_q <= sclk_i;
            cs_n_prev_q <= cs_n_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AdcIdle:  if (cs_fall) state_d = AdcShift;
            AdcShift: begin
                if (cs_rise) begin
                    state_d = AdcIdle;
                end else if (sclk_fall && fall_cnt_q == 4'(ADC_FRAME_BITS - 1)) begin
                    state_d = AdcDone;
                end
            end
            AdcDone:  if (cs_n_i) state_d = AdcIdle;
            default:  state_d = AdcIdle;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        fall_cnt_d = fall_cnt_q;
        sdata_d    = sdata_q;
        count_d    = count_q;
        abort_d    = abort_q;
        case (state_q)
            AdcIdle: begin
                sdata_d = 1'b0;
                if (cs_fall) begin
                    sdata_d    = frame[ADC_FRAME_BITS-1];
                    shift_d    = {frame[ADC_FRAME_BITS-2:0], 1'b0};
                    fall_cnt_d = '0;
                end
            end
            AdcShift: begin
                if (cs_rise) begin
                    sdata_d = 1'b0;
                    abort_d = 1'b1;
                end else if (sclk_fall) begin
                    fall_cnt_d = fall_cnt_q + 4'd1;
                    if (fall_cnt_q == 4'(ADC_FRAME_BITS - 1)) begin
                        sdata_d = 1'b0;
                        count_d = count_q + 16'd1;
                    end else begin
                        sdata_d = shift_q[ADC_FRAME_BITS-1];
                        shift_d = {shift_q[ADC_FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            default: sdata_d = 1'b0;
        endcase
    end

    assign sdata_o      = sdata_q;
    assign conv_count_o = count_q;
    assign abort_err_o  = abort_q;

endmodule

// File: rtl/stonyman_sensor_model.sv
// Stonyman sensor responder: pulse-driven register file, test-pattern pixel source and serial ADC.
// inphi pulses are only counted; the count is exposed for observability.
module stonyman_sensor_model
    import stonyman_pkg::*;
#(
    parameter logic [7:0] MAX_RES = 8'd112,
    parameter logic [7:0] SQ_R0   = 8'd46,
    parameter logic [7:0] SQ_R1   = 8'd64,
    parameter logic [7:0] SQ_C0   = 8'd41,
    parameter logic [7:0] SQ_C1   = 8'd69,
    parameter logic [7:0] DARK    = 8'h00,
    parameter logic [7:0] BRIGHT  = 8'hFF,
    parameter logic [7:0] OOR     = 8'h80
) (
    input  logic             clk,
    input  logic             reset,
    stonyman_if.slave        cam,
    output logic [7:0]       cur_row,
    output logic [7:0]       cur_col,
    output logic [15:0]      conv_count,
    output logic             abort_err,
    output logic [15:0]      inphi_count
);

    logic [4:0]  ctrl, ctrl_prev_q, ctrl_rise;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  regs_q [8];
    logic [7:0]  regs_d [8];
    logic [15:0] inphi_q, inphi_d;
    logic [7:0]  row, col, pixel;

    // Bit order: 0 resp, 1 incp, 2 resv, 3 incv, 4 inphi
    assign ctrl      = {cam.inphi, cam.incv, cam.resv, cam.incp, cam.resp};
    assign ctrl_rise = ctrl & ~ctrl_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_prev_q <= '0;
            ptr_q       <= '0;
            inphi_q     <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            ctrl_prev_q <= ctrl;
            ptr_q       <= ptr_d;
            inphi_q     <= inphi_d;
            regs_q      <= regs_d;
        end
    end

    // Value ops target the pointer as updated in the same cycle
    always_comb begin
        ptr_d   = ptr_q;
        regs_d  = regs_q;
        inphi_d = inphi_q;
        if (ctrl_rise[0])      ptr_d = '0;
        else if (ctrl_rise[1]) ptr_d = ptr_q + 3'd1;
        if (ctrl_rise[2])      regs_d[ptr_d] = '0;
        else if (ctrl_rise[3]) regs_d[ptr_d] = regs_q[ptr_d] + 8'd1;
        if (ctrl_rise[4])      inphi_d = inphi_q + 16'd1;
    end

    assign row = regs_q[REG_ROWSEL];
    assign col = regs_q[REG_COLSEL];

    always_comb begin
        pixel = BRIGHT;
        if (regs_q[REG_CONFIG][0]) begin
            pixel = row + col;
        end else if (row >= MAX_RES || col >= MAX_RES) begin
            pixel = OOR;
        end else if (row >= SQ_R0 && row <= SQ_R1 && col >= SQ_C0 && col <= SQ_C1) begin
            pixel = DARK;
        end
    end

    stonyman_adc_shifter u_adc (
        .clk_i        (clk),
        .rst_i        (reset),
        .sclk_i       (cam.sclk),
        .cs_n_i       (cam.cs_n),
        .pixel_i      (pixel),
        .sdata_o      (cam.sdata),
        .conv_count_o (conv_count),
        .abort_err_o  (abort_err)
    );

    assign cur_row     = row;
    assign cur_col     = col;
    assign inphi_count = inphi_q;

endmodule
